fsm_vedacao: RTL and testbench
==============================

Name: fsm_vedacao

Overview:
- Slave FSM for the sealing (vedação) station of the bottling line.
- Sits directly downstream of the master sequencer. It consumes the level command `cmd_vedar`, drives the capping actuator for a fixed time and consumes one cork (rolha) per bottle.
- Returns `vedacao_concluida` to the master using a 4-phase handshake.
- Owns the cork stock counter: reports `alarme_rolha` when the stock is empty and accepts refill pulses from the operator.

Parameters:
- ESTOQUE_INICIAL, 20: cork stock loaded at reset.
- ESTOQUE_MAX, 99: saturation ceiling for the stock; must be ≤ 127.
- QTD_REPOSICAO, 15: corks added per refill pulse.
- TEMPO_VEDACAO, 50_000_000: actuator-on duration in clk cycles (1 s at 50 MHz); must be ≥ 1.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_vedar  in  1  level command from the master; held high until the master sees completion or alarm.
- adicionar_rolhas  in  1  single-cycle refill pulse (debounced KEY, edge-detected upstream).
- atuador_vedacao  out  1  capping actuator enable.
- vedacao_concluida  out  1  completion flag; held until `cmd_vedar` falls.
- alarme_rolha  out  1  stock-empty alarm.
- estoque_rolhas  out  7  current stock, for the 7-segment display.

Behaviour:
- One clock domain: `clk`. Reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - estoque_rolhas = ESTOQUE_INICIAL.
  - atuador_vedacao = 0, vedacao_concluida = 0, alarme_rolha = (ESTOQUE_INICIAL == 0).
  - Timer = 0.
- Moore outputs, decoded only from the registered state and stock; no input-to-output combinational path.
  - atuador_vedacao = (state == VEDANDO).
  - vedacao_concluida = (state == CONCLUIDO).
  - alarme_rolha = (estoque == 0) AND state ∉ {VEDANDO, CONCLUIDO}. The mask prevents the master from aborting a seal that has already consumed the last cork.
- States and transitions:
  - IDLE:
    - if cmd_vedar and estoque > 0: go to VEDANDO, decrement stock, clear timer.
    - if cmd_vedar and estoque == 0: go to SEM_ROLHA.
  - VEDANDO:
    - timer increments each cycle.
    - when timer == TEMPO_VEDACAO−1: go to CONCLUIDO.
    - if cmd_vedar == 0: go to IDLE (abort). The consumed cork is not returned and concluida is never raised.
  - CONCLUIDO: stay while cmd_vedar == 1; go to IDLE when it falls.
  - SEM_ROLHA: go to IDLE when cmd_vedar == 0. A refill alone does not leave the state; the master restarts the command.
- Latency and timing:
  - `cmd_vedar` sampled high at edge t: actuator high and stock decremented from t+1.
  - The actuator stays high for exactly TEMPO_VEDACAO cycles.
  - `vedacao_concluida` rises at t+1+TEMPO_VEDACAO.
- Stock arithmetic (use ≥ 8-bit intermediate):
  - estoque_next = min(estoque − consume + (adicionar_rolhas ? QTD_REPOSICAO : 0), ESTOQUE_MAX).
  - Simultaneous consume and refill in the same cycle are both applied.
  - A refill while already at ESTOQUE_MAX has no effect.
  - The stock never underflows: consume is only possible when estoque > 0.
- Refill in SEM_ROLHA or IDLE with an empty stock clears `alarme_rolha` on the next cycle.
- Reset mid-seal: the next cycle is IDLE with stock reloaded to ESTOQUE_INICIAL; the actuator drops immediately at that edge.
- Timer width: $clog2(TEMPO_VEDACAO+1). The timer cannot run past TEMPO_VEDACAO−1 and never wraps.

Decomposition:
- Shared package (`pkg_engarrafadora`):
  - state encoding localparams: IDLE=0, VEDANDO=1, CONCLUIDO=2, SEM_ROLHA=3 (2 bits).
  - LARGURA_ESTOQUE = 7.
  - CLK_HZ = 50_000_000.
- One natural sub-module: `temporizador_ciclos`.
  - Parameter: N.
  - Inputs: clear, enable.
  - Output: fim, asserted when count == N−1.
  - Reused by the filling FSM.

Test Plan (TEMPO_VEDACAO=4, ESTOQUE_INICIAL=2, QTD_REPOSICAO=3, ESTOQUE_MAX=5):
- Nominal seal:
  - Stimulus: cmd_vedar high at cycle 10.
  - Required: atuador high cycles 11–14; estoque 2→1 at 11; concluida high from 15.
  - After cmd_vedar drops at 17: concluida low at 18, state IDLE.
- Last cork:
  - Stimulus: two back-to-back handshakes.
  - Required: the second seal takes the stock to 0, but alarme stays low through VEDANDO and CONCLUIDO.
  - Alarme rises the cycle after returning to IDLE.
- Empty stock:
  - Stimulus: cmd_vedar with estoque=0.
  - Required: SEM_ROLHA, alarme=1, atuador never high.
  - adicionar_rolhas pulse → estoque=3, alarme=0 next cycle.
  - Drop cmd_vedar → IDLE.
- Saturation and simultaneity:
  - Stimulus: estoque=4 plus refill → required 5 (clamped).
  - Stimulus: refill pulse in the same cycle as the IDLE→VEDANDO consume from estoque=1 → required 3.
- Abort and reset:
  - Stimulus: cmd_vedar drops at the 2nd VEDANDO cycle.
  - Required: IDLE next cycle, concluida never asserted, stock stays decremented.
  - Stimulus: reset asserted mid-VEDANDO.
  - Required: at the next edge, atuador=0 and estoque=ESTOQUE_INICIAL.

Source files
------------

// File: rtl/fsm_vedacao_pkg.sv
// Shared definitions for the bottling-line station FSMs.
//   estado_t         : state encoding shared by the sealing and filling FSMs
//   LARGURA_ESTOQUE  : width of the cork stock counter / display value
//   CLK_HZ           : system clock frequency
//   proximo_estoque  : saturating stock update (consume and refill in one step)
package pkg_engarrafadora;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VEDANDO   = 2'd1,
        CONCLUIDO = 2'd2,
        SEM_ROLHA = 2'd3
    } estado_t;

    localparam int unsigned LARGURA_ESTOQUE = 7;
    localparam int unsigned CLK_HZ          = 50_000_000;

    // 9-bit intermediate: 127 + 255 still fits, so the clamp sees the true sum.
    // Callers only request a consume when atual > 0, so the subtraction never wraps.
    function automatic logic [LARGURA_ESTOQUE-1:0] proximo_estoque(
        input logic [LARGURA_ESTOQUE-1:0] atual,
        input logic                       consome,
        input logic                       repoe,
        input logic [7:0]                 qtd,
        input logic [LARGURA_ESTOQUE-1:0] maximo
    );
        logic [8:0] soma;
        soma = {2'b00, atual} - {8'd0, consome} + (repoe ? {1'b0, qtd} : 9'd0);
        if (soma > {2'b00, maximo}) begin
            return maximo;
        end
        return soma[LARGURA_ESTOQUE-1:0];
    endfunction

endpackage

// File: rtl/fsm_vedacao_if.sv
// Handshake bundle between the master sequencer and the sealing station.
//   cmd_vedar         : master -> station, level seal command
//   adicionar_rolhas  : master/operator -> station, single-cycle refill pulse
//   atuador_vedacao   : station -> actuator enable
//   vedacao_concluida : station -> master, completion flag (4-phase handshake)
//   alarme_rolha      : station -> master, cork stock empty
//   estoque_rolhas    : station -> display, current cork stock
interface fsm_vedacao_if;
    import pkg_engarrafadora::*;

    logic                       cmd_vedar;
    logic                       adicionar_rolhas;
    logic                       atuador_vedacao;
    logic                       vedacao_concluida;
    logic                       alarme_rolha;
    logic [LARGURA_ESTOQUE-1:0] estoque_rolhas;

    modport master (
        output cmd_vedar,
        output adicionar_rolhas,
        input  atuador_vedacao,
        input  vedacao_concluida,
        input  alarme_rolha,
        input  estoque_rolhas
    );

    modport slave (
        input  cmd_vedar,
        input  adicionar_rolhas,
        output atuador_vedacao,
        output vedacao_concluida,
        output alarme_rolha,
        output estoque_rolhas
    );
endinterface

// File: rtl/fsm_vedacao_temporizador_ciclos.sv
// Cycle timer shared by the station FSMs.
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous clear back to 0 (has priority over enable)
//   enable     : count one cycle
//   fim        : high while the count equals N-1
// The count holds at N-1 instead of wrapping.
module temporizador_ciclos #(
    parameter int unsigned N = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);
    localparam int unsigned W = $clog2(N + 1);

    logic [W-1:0] contagem;

    assign fim = (contagem == W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            contagem <= '0;
        end else if (enable && !fim) begin
            contagem <= contagem + W'(1);
        end
    end
endmodule

// File: rtl/fsm_vedacao.sv
// Sealing-station slave FSM.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : slave side of fsm_vedacao_if (seal command, refill pulse in;
//           actuator, completion, stock alarm and stock value out)
// Takes one cork per accepted seal, runs the actuator for TEMPO_VEDACAO cycles,
// then holds completion until the master drops the command.
module fsm_vedacao
    import pkg_engarrafadora::*;
#(
    parameter int unsigned ESTOQUE_INICIAL = 20,
    parameter int unsigned ESTOQUE_MAX     = 99,
    parameter int unsigned QTD_REPOSICAO   = 15,
    parameter int unsigned TEMPO_VEDACAO   = 50_000_000
) (
    input  logic            clk,
    input  logic            reset,
    fsm_vedacao_if.slave    bus
);
    localparam logic [LARGURA_ESTOQUE-1:0] EST_INI = LARGURA_ESTOQUE'(ESTOQUE_INICIAL);
    localparam logic [LARGURA_ESTOQUE-1:0] EST_MAX = LARGURA_ESTOQUE'(ESTOQUE_MAX);
    localparam logic [7:0]                 QTD_REP = 8'(QTD_REPOSICAO);

    estado_t                    estado, estado_prox;
    logic [LARGURA_ESTOQUE-1:0] estoque, estoque_prox;
    logic                       consome;
    logic                       fim_tempo;

    // Held at zero outside VEDANDO, so every seal starts from a fresh count.
    temporizador_ciclos #(.N(TEMPO_VEDACAO)) u_temporizador (
        .clk    (clk),
        .reset  (reset),
        .clear  (estado != VEDANDO),
        .enable (estado == VEDANDO),
        .fim    (fim_tempo)
    );

    always_comb begin
        estado_prox = estado;
        consome     = 1'b0;
        unique case (estado)
            IDLE: begin
                if (bus.cmd_vedar) begin
                    if (estoque != '0) begin
                        estado_prox = VEDANDO;
                        consome     = 1'b1;
                    end else begin
                        estado_prox = SEM_ROLHA;
                    end
                end
            end
            VEDANDO: begin
                // A dropped command aborts even on the last timed cycle.
                if (!bus.cmd_vedar) begin
                    estado_prox = IDLE;
                end else if (fim_tempo) begin
                    estado_prox = CONCLUIDO;
                end
            end
            CONCLUIDO: begin
                if (!bus.cmd_vedar) begin
                    estado_prox = IDLE;
                end
            end
            SEM_ROLHA: begin
                if (!bus.cmd_vedar) begin
                    estado_prox = IDLE;
                end
            end
            default: estado_prox = IDLE;
        endcase
        estoque_prox = proximo_estoque(estoque, consome, bus.adicionar_rolhas, QTD_REP, EST_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado  <= IDLE;
            estoque <= EST_INI;
        end else begin
            estado  <= estado_prox;
            estoque <= estoque_prox;
        end
    end

    // Moore outputs. The alarm is masked while a seal that already took the
    // last cork is in progress or awaiting acknowledgement.
    assign bus.atuador_vedacao   = (estado == VEDANDO);
    assign bus.vedacao_concluida = (estado == CONCLUIDO);
    assign bus.alarme_rolha      = (estoque == '0) && (estado != VEDANDO) && (estado != CONCLUIDO);
    assign bus.estoque_rolhas    = estoque;
endmodule

// File: tb/tb_fsm_vedacao.sv
module tb_fsm_vedacao;
    localparam int unsigned T_VED = 4;
    localparam int unsigned E_INI = 2;
    localparam int unsigned QTD   = 3;
    localparam int unsigned E_MAX = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fsm_vedacao_if bus ();

    fsm_vedacao #(
        .ESTOQUE_INICIAL (E_INI),
        .ESTOQUE_MAX     (E_MAX),
        .QTD_REPOSICAO   (QTD),
        .TEMPO_VEDACAO   (T_VED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       cmd;
        logic       add;
        logic       rst;
        logic       atu;
        logic       conc;
        logic       alm;
        logic [6:0] est;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic c, input logic a, input logic r,
                              input logic atu, input logic conc, input logic alm,
                              input int est);
        vec_t x;
        x.cmd = c; x.add = a; x.rst = r;
        x.atu = atu; x.conc = conc; x.alm = alm; x.est = 7'(est);
        vecs.push_back(x);
    endfunction

    function automatic logic [9:0] saidas();
        return {bus.atuador_vedacao, bus.vedacao_concluida, bus.alarme_rolha, bus.estoque_rolhas};
    endfunction

    task automatic check(input string nome, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got atu/conc/alm/est=%b/%b/%b/%0d required %b/%b/%b/%0d",
                     nome, got[9], got[8], got[7], got[6:0], exp[9], exp[8], exp[7], exp[6:0]);
        end
    endtask

    task automatic check_int(input string nome, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nome, got, exp);
        end
    endtask

    task automatic step(input logic c, input logic a, input logic r);
        bus.cmd_vedar        = c;
        bus.adicionar_rolhas = a;
        reset                = r;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a seal is a countdown of remaining actuator cycles,
    // completion and "no cork" are waiting flags released by a low command.
    int m_stock, m_left;
    bit m_done, m_blocked;

    function automatic void m_reset();
        m_stock = E_INI; m_left = 0; m_done = 0; m_blocked = 0;
    endfunction

    function automatic void m_step(input bit c, input bit a, input bit r);
        int use_cork;
        if (r) begin
            m_reset();
            return;
        end
        use_cork = 0;
        if (m_left > 0) begin
            if (!c)               m_left = 0;
            else if (m_left == 1) begin m_left = 0; m_done = 1; end
            else                  m_left--;
        end else if (m_done) begin
            if (!c) m_done = 0;
        end else if (m_blocked) begin
            if (!c) m_blocked = 0;
        end else if (c) begin
            if (m_stock > 0) begin use_cork = 1; m_left = T_VED; end
            else             m_blocked = 1;
        end
        m_stock = m_stock - use_cork + (a ? QTD : 0);
        if (m_stock > E_MAX) m_stock = E_MAX;
    endfunction

    function automatic logic [9:0] m_saidas();
        logic sealing;
        sealing = (m_left > 0);
        return {sealing, 1'(m_done), (m_stock == 0) && !sealing && !m_done, 7'(m_stock)};
    endfunction

    initial begin
        int  n_atu, n_edges;
        bit  seen;
        bit  c, a, r;

        bus.cmd_vedar = 1'b0;
        bus.adicionar_rolhas = 1'b0;

        step(0, 0, 1);
        step(0, 0, 1);
        check("reset", saidas(), {1'b0, 1'b0, 1'b0, 7'd2});

        // nominal seal
        v(0,0,0, 0,0,0,2);
        v(1,0,0, 1,0,0,1); v(1,0,0, 1,0,0,1); v(1,0,0, 1,0,0,1); v(1,0,0, 1,0,0,1);
        v(1,0,0, 0,1,0,1); v(1,0,0, 0,1,0,1);
        v(0,0,0, 0,0,0,1);
        // last cork: alarm masked until back in IDLE
        v(1,0,0, 1,0,0,0); v(1,0,0, 1,0,0,0); v(1,0,0, 1,0,0,0); v(1,0,0, 1,0,0,0);
        v(1,0,0, 0,1,0,0);
        v(0,0,0, 0,0,1,0);
        // empty stock, refill inside SEM_ROLHA, stay until command drops
        v(1,0,0, 0,0,1,0); v(1,0,0, 0,0,1,0);
        v(1,1,0, 0,0,0,3);
        v(1,0,0, 0,0,0,3);
        v(0,0,0, 0,0,0,3);
        // abort at second VEDANDO cycle
        v(1,0,0, 1,0,0,2); v(1,0,0, 1,0,0,2);
        v(0,0,0, 0,0,0,2); v(0,0,0, 0,0,0,2);
        // refill and saturation
        v(0,1,0, 0,0,0,5); v(0,1,0, 0,0,0,5);
        v(1,0,0, 1,0,0,4); v(0,0,0, 0,0,0,4);
        v(0,1,0, 0,0,0,5);
        // drain to 1 with aborted seals
        v(1,0,0, 1,0,0,4); v(0,0,0, 0,0,0,4);
        v(1,0,0, 1,0,0,3); v(0,0,0, 0,0,0,3);
        v(1,0,0, 1,0,0,2); v(0,0,0, 0,0,0,2);
        v(1,0,0, 1,0,0,1); v(0,0,0, 0,0,0,1);
        // consume and refill in the same cycle: 1 - 1 + 3
        v(1,1,0, 1,0,0,3); v(0,0,0, 0,0,0,3);
        // reset mid-seal
        v(0,1,0, 0,0,0,5);
        v(1,0,0, 1,0,0,4); v(1,0,0, 1,0,0,4);
        v(1,0,1, 0,0,0,2);
        v(1,0,0, 1,0,0,1);
        v(0,0,0, 0,0,0,1);

        foreach (vecs[i]) begin
            step(vecs[i].cmd, vecs[i].add, vecs[i].rst);
            check($sformatf("vec%0d", i), saidas(),
                  {vecs[i].atu, vecs[i].conc, vecs[i].alm, vecs[i].est});
        end

        // actuator duration and completion latency, bounded wait
        step(1, 0, 0);
        n_atu = bus.atuador_vedacao ? 1 : 0;
        n_edges = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1, 0, 0);
            n_edges++;
            if (bus.atuador_vedacao) n_atu++;
            if (bus.vedacao_concluida) seen = 1;
        end
        check_int("concluida_seen", int'(seen), 1);
        check_int("atuador_cycles", n_atu, T_VED);
        check_int("concluida_latency", n_edges, T_VED);
        step(0, 0, 0);
        check("handshake_release", saidas(), {1'b0, 1'b0, 1'b1, 7'd0});

        // randomized against the reference model
        step(0, 0, 1);
        m_reset();
        c = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) c = ~c;
            a = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 299) == 0);
            m_step(c, a, r);
            step(c, a, r);
            check("random", saidas(), m_saidas());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
